oc_line_arbiter: RTL and testbench
==================================

Name: oc_line_arbiter

Overview:
- Round-robin arbiter sharing one open-collector control line (SMS wired-OR net) among N requesters.
- Sequences ownership: grant, drive while owned, then a pull-up settle interval before the next grant.
- Monitors the line for stuck-low faults.
- Sits between CTRL-card logic blocks that must time-share a common open-collector trigger/control net.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SETTLE_CYCLES, 2, cycles the line is released after an owner lets go, before re-arbitration (0..15).
- MAX_HOLD, 16, maximum cycles one owner may hold the line; used only with the optional feature (1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester ownership request, level-sensitive.
- drv  input  N_REQ  per-requester drive value; 1 = pull line low.
- line_in  input  1  sensed level of the shared net (pulled up externally).
- gnt  output  N_REQ  one-hot grant; all zero when no owner.
- line_oc  output  1  open-collector drive: 0 when pulling, 1'bz otherwise; never drives 1.
- busy  output  1  high whenever state is not IDLE.
- stuck_err  output  1  sticky: line held low while nobody drives.
- timeout  output  1  one-cycle pulse on forced release; tied 0 without the feature.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, gnt=0, line_oc=z, busy=0, stuck_err=0, timeout=0, rr pointer=0, all counters=0. Reset asserted mid-ownership releases the line in the same instant, not at the next edge.
- States: IDLE, OWN, SETTLE.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from ptr with wrap (ptr, ptr+1 … N_REQ-1, 0 …).
  - Next edge: gnt=onehot(winner), state OWN, ptr=(winner+1) mod N_REQ.
  - Latency from req to gnt: 1 cycle.
- OWN:
  - gnt held stable.
  - line_oc is combinational from registered gnt: 0 iff drv[owner]=1, else z. Other requesters' drv bits are ignored.
  - When req[owner]=0 at an edge: gnt=0 and the line is released at that edge. Next state is SETTLE if SETTLE_CYCLES>0, else IDLE.
- SETTLE:
  - gnt=0, line_oc=z.
  - Down-counter loaded with SETTLE_CYCLES-1 on entry; exits to IDLE when it reaches 0.
  - Requests arriving during SETTLE are held off; they are evaluated in IDLE.
  - Release-to-next-grant gap is exactly SETTLE_CYCLES+1 cycles of gnt=0.
- Request behaviour:
  - Requests are not latched. A req that drops before it is granted is forgotten.
  - A single continuously requesting requester is re-granted after every settle interval.
- Stuck detection:
  - In IDLE or SETTLE, line_in=0 on 2 consecutive edges sets stuck_err.
  - stuck_err clears only on reset.
  - Arbitration continues regardless of stuck_err.
- line_in=x/z: treat z as 1 (pulled up), consistent with SMS input handling.

Optional Feature:
- Macro: OC_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OWN and increments each OWN cycle.
  - If the counter reaches MAX_HOLD while req[owner] is still 1, release is forced exactly as a normal release (gnt=0, line z, SETTLE/IDLE), and timeout pulses high for 1 cycle on that edge.
  - ptr already points past the owner, so the next-in-line wins.
  - If req[owner] drops on the same edge the limit is hit, it is a normal release with no timeout pulse.
- Undefined: no hold counter; ownership is unbounded; the timeout port exists and is constant 0.

Test Plan:
- Reset mid-OWN with drv=1 (line_oc=0): assert rst_n=0 between edges -> line_oc=z and gnt=0 before the next edge; all outputs at reset values.
- req=4'b0101 from IDLE, ptr=0: gnt=0001 one cycle later; drop req[0] -> gnt=0 for 3 cycles (SETTLE_CYCLES=2), then gnt=0100.
- All four req held high and each owner drops after 1 cycle: grant order 0,1,2,3,0 with no requester skipped.
- SETTLE_CYCLES=0, single requester toggling: exactly 1 gap cycle between grants.
- line_in forced 0 for 2 cycles in IDLE -> stuck_err=1; it persists through subsequent grants until rst_n.
- With OC_ARB_TIMEOUT_EN, MAX_HOLD=16, req[1] held forever alongside req[2]: forced release after 16 OWN cycles with a 1-cycle timeout pulse, then gnt=0100 after settle. Without the macro, req[1] stays granted for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/oc_line_arbiter.sv
// ---------------------------------------------------------------------------
// oc_line_arbiter
// Round-robin owner sequencing for one shared open-collector control net.
// An owner is granted, may pull the line low while it holds the grant, and
// after release the line is left to the pull-up for SETTLE_CYCLES before the
// next arbitration. A stuck-low monitor flags the net held low while idle.
//
// Optional feature macro: OC_ARB_TIMEOUT_EN
//   defined   -> ownership limited to MAX_HOLD cycles, timeout pulses on a
//                forced release
//   undefined -> unbounded ownership, timeout tied 0
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester level request
//   drv        per-requester drive value (1 = pull line low), owner only
//   line_in    sensed level of the shared net
//   gnt        one-hot grant, zero when no owner
//   line_oc    open-collector drive: 0 or z, never 1
//   busy       arbiter not idle
//   stuck_err  sticky stuck-low flag
//   timeout    one-cycle forced-release pulse
// ---------------------------------------------------------------------------
module oc_line_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned MAX_HOLD      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] drv,
   input  logic             line_in,
   output logic [N_REQ-1:0] gnt,
   output logic             line_oc,
   output logic             busy,
   output logic             stuck_err,
   output logic             timeout
);

   localparam int unsigned PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned IDX_W       = PTR_W + 1;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned HOLD_W      = 8;
   localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

   // Elaboration-time parameter range guard
   if (N_REQ < 2 || N_REQ > 8 || SETTLE_CYCLES > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
      $error("oc_line_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN    = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               stuck_q, stuck_d;
   logic               low_prev_q, low_prev_d;

   logic               any_req;
   logic [PTR_W-1:0]   win;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   win_nxt;
   logic               owner_req;
   logic               hold_hit;
   logic               rel;
   logic               idle_like;
   logic               line_low;

   // A floating (z) net reads as the pulled-up level, never as low
   assign line_low  = (line_in === 1'b0);
   assign owner_req = |(req & gnt_q);
   assign idle_like = (state_q != ST_OWN);
   assign rel       = (state_q == ST_OWN) && (!owner_req || hold_hit);

   // Round-robin search: first set req bit at or above ptr, with wrap
   always_comb begin : arb
      any_req = 1'b0;
      win     = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = IDX_W'(ptr_q) + IDX_W'(i);
         if (cand >= IDX_W'(N_REQ)) cand = cand - IDX_W'(N_REQ);
         if (!any_req && req[cand[PTR_W-1:0]]) begin
            any_req = 1'b1;
            win     = cand[PTR_W-1:0];
         end
      end
      win_nxt = IDX_W'(win) + IDX_W'(1);
      if (win_nxt == IDX_W'(N_REQ)) win_nxt = '0;
   end

`ifdef OC_ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              force_rel;
   logic              timeout_q;

   // Limit reached on the MAX_HOLD-th owned cycle
   assign hold_hit  = (hold_q == HOLD_W'(MAX_HOLD - 1));
   assign force_rel = (state_q == ST_OWN) && owner_req && hold_hit;

   // Hold counter: zero while idle so it starts clean on entry to OWN
   always_comb begin : hold_next
      hold_d = hold_q;
      if (state_q == ST_IDLE)
         hold_d = '0;
      else if (state_q == ST_OWN && owner_req && !hold_hit)
         hold_d = hold_q + HOLD_W'(1);
   end

   // Hold counter and timeout pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= force_rel;
      end
   end

   assign timeout = timeout_q;
`else
   assign hold_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         stuck_q    <= 1'b0;
         low_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         stuck_q    <= stuck_d;
         low_prev_q <= low_prev_d;
      end
   end

   // Next-state logic
   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (any_req) state_d = ST_OWN;
         ST_OWN:    if (rel) state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_IDLE;
         ST_SETTLE: if (cnt_q == '0) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Grant, pointer, settle counter and stuck-low monitor updates
   always_comb begin : fsm_out
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      stuck_d    = stuck_q | (idle_like & line_low & low_prev_q);
      low_prev_d = idle_like & line_low;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               gnt_d = N_REQ'(1) << win;
               ptr_d = win_nxt[PTR_W-1:0];
               cnt_d = '0;
            end
         end
         ST_OWN: begin
            if (rel) begin
               gnt_d = '0;
               cnt_d = CNT_W'(SETTLE_LOAD);
            end
         end
         ST_SETTLE: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         end
         default: gnt_d = '0;
      endcase
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != ST_IDLE);
   assign stuck_err = stuck_q;
   // Drive follows the registered grant so reset releases the net at once
   assign line_oc   = (|(drv & gnt_q)) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_oc_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oc_line_arbiter
// Scoreboard bench for oc_line_arbiter. Two instances share stimulus: one
// with SETTLE_CYCLES=2, one with SETTLE_CYCLES=0. A behavioural model of
// ownership (owner index, settle time left, hold time) runs on each rising
// edge and queues the expected outputs; a monitor on the falling edge pops
// and compares. Honours OC_ARB_TIMEOUT_EN like the design.
// ---------------------------------------------------------------------------
module tb_oc_line_arbiter;

   localparam int N    = 4;
   localparam int MAXH = 16;
`ifdef OC_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] req   = '0;
   logic [N-1:0] drv   = '0;
   logic         line_in = 1'b1;

   logic [N-1:0] gnt_a, gnt_b;
   wire          line_a, line_b;
   logic         busy_a, busy_b, stuck_a, stuck_b, to_a, to_b;

   pullup (line_a);
   pullup (line_b);

   oc_line_arbiter #(.N_REQ(N), .SETTLE_CYCLES(2), .MAX_HOLD(MAXH)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .drv(drv), .line_in(line_in),
      .gnt(gnt_a), .line_oc(line_a), .busy(busy_a), .stuck_err(stuck_a), .timeout(to_a));

   oc_line_arbiter #(.N_REQ(N), .SETTLE_CYCLES(0), .MAX_HOLD(MAXH)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .drv(drv), .line_in(line_in),
      .gnt(gnt_b), .line_oc(line_b), .busy(busy_b), .stuck_err(stuck_b), .timeout(to_b));

   always #5 clk = ~clk;

   typedef struct {
      int owner;        // -1 when nobody owns the line
      int ptr;
      int settle_left;  // released cycles still to wait
      int held;         // completed owned cycles
      bit prev_low;
      bit stuck;
      bit to;
   } model_t;

   typedef struct {
      int owner;
      bit busy;
      bit stuck;
      bit to;
   } exp_t;

   model_t ma, mb;
   exp_t   qa[$];
   exp_t   qb[$];
   int     checks = 0;
   int     errors = 0;

   function automatic model_t reset_model();
      model_t m;
      m.owner = -1; m.ptr = 0; m.settle_left = 0; m.held = 0;
      m.prev_low = 1'b0; m.stuck = 1'b0; m.to = 1'b0;
      return m;
   endfunction

   // One clock edge of the ownership rules
   function automatic model_t step(model_t m, int settle, logic [N-1:0] r, bit low);
      model_t n = m;
      bit found = 1'b0;
      n.to = 1'b0;
      if (m.owner < 0) begin
         if (low && m.prev_low) n.stuck = 1'b1;
         n.prev_low = low;
      end else begin
         n.prev_low = 1'b0;
      end
      if (m.owner >= 0) begin
         if (!r[m.owner]) begin
            n.owner = -1; n.settle_left = settle;
         end else if (TO_EN && (m.held + 1 >= MAXH)) begin
            n.owner = -1; n.settle_left = settle; n.to = 1'b1;
         end else begin
            n.held = m.held + 1;
         end
      end else if (m.settle_left > 0) begin
         n.settle_left = m.settle_left - 1;
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m.ptr + k) % N;
            if (!found && r[c]) begin
               found = 1'b1; n.owner = c; n.ptr = (c + 1) % N; n.held = 0;
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t to_exp(model_t m);
      exp_t e;
      e.owner = m.owner;
      e.busy  = (m.owner >= 0) || (m.settle_left > 0);
      e.stuck = m.stuck;
      e.to    = m.to;
      return e;
   endfunction

   function automatic int line_val(logic l);
      return (l === 1'b1) ? 1 : ((l === 1'b0) ? 0 : 2);
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_vals();
      cmp("rst_gnt_a",   int'(gnt_a), 0);
      cmp("rst_gnt_b",   int'(gnt_b), 0);
      cmp("rst_line_a",  line_val(line_a), 1);
      cmp("rst_line_b",  line_val(line_b), 1);
      cmp("rst_busy_a",  int'(busy_a), 0);
      cmp("rst_busy_b",  int'(busy_b), 0);
      cmp("rst_stuck_a", int'(stuck_a), 0);
      cmp("rst_stuck_b", int'(stuck_b), 0);
      cmp("rst_to_a",    int'(to_a), 0);
      cmp("rst_to_b",    int'(to_b), 0);
   endtask

   task automatic chk_exp(input string tag, input exp_t e, input logic [N-1:0] g,
                          input logic l, input logic b, input logic s, input logic t);
      int eg;
      int el;
      eg = (e.owner >= 0) ? (1 << e.owner) : 0;
      el = (e.owner >= 0 && drv[e.owner]) ? 0 : 1;
      cmp({tag, "_gnt"},     int'(g), eg);
      cmp({tag, "_line"},    line_val(l), el);
      cmp({tag, "_busy"},    int'(b), int'(e.busy));
      cmp({tag, "_stuck"},   int'(s), int'(e.stuck));
      cmp({tag, "_timeout"}, int'(t), int'(e.to));
   endtask

   // Reference model: advance on each rising edge and queue expectations
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            ma = reset_model();
            mb = reset_model();
         end else begin
            ma = step(ma, 2, req, line_in == 1'b0);
            mb = step(mb, 0, req, line_in == 1'b0);
            qa.push_back(to_exp(ma));
            qb.push_back(to_exp(mb));
         end
      end
   end

   // Monitor: compare DUT outputs mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            qa.delete();
            qb.delete();
            chk_reset_vals();
         end else begin
            if (qa.size() > 0) begin
               e = qa.pop_front();
               chk_exp("a", e, gnt_a, line_a, busy_a, stuck_a, to_a);
            end
            if (qb.size() > 0) begin
               e = qb.pop_front();
               chk_exp("b", e, gnt_b, line_b, busy_b, stuck_b, to_b);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int w;
      #1 rst_n = 1'b0;
      #2 chk_reset_vals();
      repeat (2) tick();
      rst_n = 1'b1;

      // Two requesters from idle, owner 0 drops after a few cycles
      req = 4'b0101;
      repeat (3) tick();
      req = 4'b0100;
      repeat (8) tick();
      req = '0;
      repeat (4) tick();

      // All requesting, each owner drops as soon as it is granted
      repeat (24) begin
         req = 4'hF & ~gnt_a;
         drv = N'($urandom);
         tick();
      end
      req = '0;
      repeat (4) tick();

      // Single requester toggling against the zero-settle instance
      repeat (12) begin
         req = gnt_b[0] ? 4'b0000 : 4'b0001;
         tick();
      end
      req = '0;
      repeat (3) tick();

      // Stuck-low while idle, then keep arbitrating
      repeat (2) tick();
      line_in = 1'b0;
      repeat (2) tick();
      line_in = 1'b1;
      repeat (16) begin
         req = N'($urandom);
         drv = N'($urandom);
         tick();
      end
      req = '0;
      repeat (4) tick();
      do_reset();

      // Long hold by requester 1 with requester 2 waiting
      req = 4'b0110;
      repeat (120) begin
         drv = N'($urandom);
         tick();
      end
      req = '0;
      repeat (5) tick();
      do_reset();

      // Randomized traffic with periodic resets
      for (int i = 0; i < 1500; i++) begin
         if (i % 500 == 499) do_reset();
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         drv = N'($urandom);
         line_in = ($urandom_range(0, 19) != 0);
         tick();
      end
      req = '0;
      line_in = 1'b1;
      repeat (4) tick();

      // Reset between edges while the owner pulls the line low
      do_reset();
      req = 4'b0001;
      drv = 4'b0001;
      w = 0;
      while (gnt_a != 4'b0001 && w < 10) begin
         tick();
         w++;
      end
      cmp("own_granted", int'(gnt_a), 1);
      cmp("own_pull", line_val(line_a), 0);
      #1 rst_n = 1'b0;
      #1;
      chk_reset_vals();
      repeat (2) tick();
      rst_n = 1'b1;
      req = '0;
      drv = '0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
